// File: rtl/montgomery_reduce_word_serial.sv
// Word-serial Montgomery reduction: result = T * R^-1 mod N, R = 2^(REGISTER_SIZE*N_BLOCKS).
// T streams in LS block first (2*N_BLOCKS beats) and is reduced in place in one buffer.
// Result streams out LS block first (N_BLOCKS beats) with valid/ready backpressure.
// Optional build macro MONT_REDUCE_LAZY_EN: skip the final subtraction, output t in [0,2N)
// with the top overflow bit on overflow_out.
//
// state   | meaning
// IDLE    | waiting for first T beat, ready_out high
// LOAD    | writing T beats into the buffer
// MSTEP   | read T[i], form m = T[i]*n' mod 2^W (2 cycles)
// ACCUM   | T[i+j] += m*N[j] + c for j = 0..N_BLOCKS-1, pipelined one j per cycle
// PROP    | ripple remaining carry upward from T[i+N_BLOCKS]
// SUB     | d = {ovf,T[hi]} - N into T[lo], capture final borrow
// OUT     | stream selected half with handshake
module montgomery_reduce_word_serial #(
    parameter int REGISTER_SIZE = 32,
    parameter int N_BLOCKS      = 128
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        valid_in,
    input  logic [REGISTER_SIZE-1:0]    T_block_in,
    output logic                        ready_out,
    input  logic [REGISTER_SIZE-1:0]    n_prime_in,
    output logic [$clog2(N_BLOCKS)-1:0] modN_addr_out,
    input  logic [REGISTER_SIZE-1:0]    modN_block_in,
    output logic                        valid_out,
    output logic [REGISTER_SIZE-1:0]    data_block_out,
    output logic                        last_out,
    input  logic                        out_ready_in,
    output logic                        busy_out,
    output logic                        overflow_out
);

    localparam int W   = REGISTER_SIZE;
    localparam int NB  = N_BLOCKS;
    localparam int TB  = 2 * N_BLOCKS;
    localparam int AW  = $clog2(NB);
    localparam int TAW = $clog2(TB);
    localparam int CW  = $clog2(TB) + 1;

    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] NB_C  = CW'(NB);
    localparam logic [CW-1:0] TB_C  = CW'(TB);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MSTEP, S_ACCUM, S_PROP, S_SUB, S_OUT
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_mem [0:TB-1];
    logic [W-1:0]    r_rd_data;
    logic [W-1:0]    r_np;
    logic [W-1:0]    r_m;
    logic [W-1:0]    r_c;
    logic            r_ovf;
    logic            r_bw;
    logic            r_sel;
    logic [CW-1:0]   r_i;
    logic [CW-1:0]   r_j;
    logic [CW-1:0]   r_wa;
    logic            r_pend;
    logic            r_ms;
    logic            r_ready;
    logic            r_valid;
    logic            r_last;
    logic            r_busy;
    logic            r_ovf_out;
    logic [W-1:0]    r_data;

    logic            w_accept;
    logic            w_hs;
    logic [W-1:0]    w_m;
    logic [2*W-1:0]  w_mac;
    logic [W:0]      w_padd;
    logic [W:0]      w_sub;
    logic [W-1:0]    w_c_now;
    logic            w_ovf_next;
    logic [CW-1:0]   w_out_base;
    logic [TAW-1:0]  w_rd_addr;
    logic            w_we;
    logic [TAW-1:0]  w_wa;
    logic [W-1:0]    w_wd;

    assign ready_out      = r_ready;
    assign valid_out      = r_valid;
    assign data_block_out = r_data;
    assign last_out       = r_last;
    assign busy_out       = r_busy;
    assign overflow_out   = r_ovf_out;
    assign modN_addr_out  = r_j[AW-1:0];

    assign w_accept   = valid_in & r_ready & ((r_state == S_IDLE) | (r_state == S_LOAD));
    assign w_hs       = r_valid & out_ready_in;
    assign w_m        = r_rd_data * r_np;
    assign w_mac      = {{W{1'b0}}, r_rd_data}
                      + ({{W{1'b0}}, r_m} * {{W{1'b0}}, modN_block_in})
                      + {{W{1'b0}}, r_c};
    assign w_padd     = {1'b0, r_rd_data} + {1'b0, r_c};
    assign w_sub      = {1'b0, r_rd_data} - {1'b0, modN_block_in} - {{W{1'b0}}, r_bw};
    // After the first PROP word the carry can only be 0 or 1.
    assign w_c_now    = r_pend ? {{(W-1){1'b0}}, w_padd[W]} : r_c;
    assign w_ovf_next = r_ovf | (r_pend & (r_wa == TB_C - ONE_C) & w_padd[W]);
    assign w_out_base = r_sel ? '0 : NB_C;

    // Buffer read address and write port selection per state.
    always_comb begin
        w_rd_addr = '0;
        w_we      = 1'b0;
        w_wa      = TAW'(r_wa);
        w_wd      = '0;
        case (r_state)
            S_IDLE: begin
                w_we = w_accept;
                w_wa = '0;
                w_wd = T_block_in;
            end
            S_LOAD: begin
                w_we = w_accept;
                w_wa = TAW'(r_j);
                w_wd = T_block_in;
            end
            S_MSTEP: w_rd_addr = TAW'(r_i);
            S_ACCUM: begin
                w_rd_addr = TAW'(r_i + r_j);
                w_we      = r_pend;
                w_wd      = w_mac[W-1:0];
            end
            S_PROP: begin
                w_rd_addr = TAW'(r_j);
                w_we      = r_pend;
                w_wd      = w_padd[W-1:0];
            end
            S_SUB: begin
                w_rd_addr = TAW'(NB_C + r_j);
                w_we      = r_pend;
                w_wd      = w_sub[W-1:0];
            end
            S_OUT: w_rd_addr = TAW'(w_out_base + (w_hs ? r_j + ONE_C : r_j));
            default: w_rd_addr = '0;
        endcase
    end

    // T buffer: one write and one registered read per cycle.
    always_ff @(posedge clk_in) begin
        if (w_we) r_mem[w_wa] <= w_wd;
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf_out <= 1'b0;
            r_data    <= '0;
            r_np      <= '0;
            r_m       <= '0;
            r_c       <= '0;
            r_ovf     <= 1'b0;
            r_bw      <= 1'b0;
            r_sel     <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_wa      <= '0;
            r_pend    <= 1'b0;
            r_ms      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_np    <= n_prime_in;
                        r_ovf   <= 1'b0;
                        r_j     <= ONE_C;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_j <= r_j + ONE_C;
                        if (r_j == TB_C - ONE_C) begin
                            r_ready <= 1'b0;
                            r_i     <= '0;
                            r_ms    <= 1'b0;
                            r_state <= S_MSTEP;
                        end
                    end
                end
                S_MSTEP: begin
                    if (!r_ms) begin
                        r_ms <= 1'b1;
                    end else begin
                        r_ms    <= 1'b0;
                        r_m     <= w_m;
                        r_c     <= '0;
                        r_j     <= '0;
                        r_pend  <= 1'b0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (r_pend) r_c <= w_mac[2*W-1:W];
                    r_pend <= (r_j < NB_C);
                    r_wa   <= r_i + r_j;
                    r_j    <= r_j + ONE_C;
                    if (r_j == NB_C) begin
                        r_pend  <= 1'b0;
                        r_j     <= r_i + NB_C;
                        r_state <= S_PROP;
                    end
                end
                S_PROP: begin
                    r_ovf <= w_ovf_next;
                    if ((w_c_now == '0) || (r_j == TB_C)) begin
                        r_pend <= 1'b0;
                        if (r_i == NB_C - ONE_C) begin
`ifdef MONT_REDUCE_LAZY_EN
                            r_sel     <= 1'b0;
                            r_ovf_out <= w_ovf_next;
                            r_j       <= '0;
                            r_state   <= S_OUT;
`else
                            r_j     <= '0;
                            r_bw    <= 1'b0;
                            r_state <= S_SUB;
`endif
                        end else begin
                            r_i     <= r_i + ONE_C;
                            r_ms    <= 1'b0;
                            r_state <= S_MSTEP;
                        end
                    end else begin
                        r_pend <= 1'b1;
                        r_wa   <= r_j;
                        r_j    <= r_j + ONE_C;
                        r_c    <= w_c_now;
                    end
                end
                S_SUB: begin
                    if (r_pend) r_bw <= w_sub[W];
                    r_pend <= (r_j < NB_C);
                    r_wa   <= r_j;
                    r_j    <= r_j + ONE_C;
                    if (r_j == NB_C) begin
                        // t >= N when the top bit is set or the subtraction did not borrow.
                        r_sel   <= r_ovf | ~w_sub[W];
                        r_pend  <= 1'b0;
                        r_j     <= '0;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (r_valid) begin
                        if (out_ready_in) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (r_last) begin
                                r_data    <= '0;
                                r_ovf_out <= 1'b0;
                                r_busy    <= 1'b0;
                                r_ready   <= 1'b1;
                                r_j       <= '0;
                                r_state   <= S_IDLE;
                            end else begin
                                r_j    <= r_j + ONE_C;
                                r_pend <= 1'b1;
                            end
                        end
                    end else if (r_pend) begin
                        r_data  <= r_rd_data;
                        r_valid <= 1'b1;
                        r_last  <= (r_j == NB_C - ONE_C);
                        r_pend  <= 1'b0;
                    end else begin
                        r_pend <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_word_serial.sv
// Directed and swept checks for montgomery_reduce_word_serial with W=8, N_BLOCKS=2,
// N=0xF1 (241), n'=0xEF, R=2^16 (R^-1 mod 241 = 15).
// Define MONT_REDUCE_LAZY_EN for the lazy build as well as for the design.
module tb_montgomery_reduce_word_serial;

    localparam int LAT_MAX = 2 * (2 * 2 + 6) + 2 + 8;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       valid_in;
    logic [7:0] T_block_in;
    logic       ready_out;
    logic [7:0] n_prime_in;
    logic [0:0] modN_addr_out;
    logic [7:0] modN_block_in;
    logic       valid_out;
    logic [7:0] data_block_out;
    logic       last_out;
    logic       out_ready_in;
    logic       busy_out;
    logic       overflow_out;

    int n_checks = 0;
    int n_errors = 0;

    montgomery_reduce_word_serial #(.REGISTER_SIZE(8), .N_BLOCKS(2)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .T_block_in    (T_block_in),
        .ready_out     (ready_out),
        .n_prime_in    (n_prime_in),
        .modN_addr_out (modN_addr_out),
        .modN_block_in (modN_block_in),
        .valid_out     (valid_out),
        .data_block_out(data_block_out),
        .last_out      (last_out),
        .out_ready_in  (out_ready_in),
        .busy_out      (busy_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    // N memory with one cycle of read latency.
    always @(posedge clk_in) modN_block_in <= (modN_addr_out == 1'b0) ? 8'hF1 : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_reduce(input logic [31:0] t);
        return 16'(((t % 241) * 15) % 241);
    endfunction

    task automatic send_t(input logic [31:0] t, input bit gap, input bit junk);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_in);
            if (gap && b == 2) begin
                valid_in   = 1'b0;
                T_block_in = 8'h5A;
                @(negedge clk_in);
            end
            if (b == 0 || b == 3) check_eq("ready_load", ready_out, 1);
            valid_in   = 1'b1;
            T_block_in = t[8*b +: 8];
            n_prime_in = 8'hEF;
        end
        @(negedge clk_in);
        valid_in   = junk;
        T_block_in = junk ? 8'hFF : 8'h00;
        check_eq("ready_drop", ready_out, 0);
        check_eq("busy_run", busy_out, 1);
    endtask

    task automatic collect(input bit toggle, output logic [16:0] res, output int lat);
        int   beats = 0;
        int   cyc   = 0;
        int   vcnt  = 0;
        bit   hold  = 0;
        bit   rdy;
        logic [7:0] hd = '0;
        logic       hl = 1'b0;
        res = '0;
        lat = -1;
        while (beats < 2 && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
            if (hold) begin
                check_eq("hold_valid", valid_out, 1);
                check_eq("hold_data", data_block_out, hd);
                check_eq("hold_last", last_out, hl);
            end
            rdy = 1'b1;
            if (valid_out) begin
                valid_in = 1'b0;
                if (lat < 0) lat = cyc;
                if (toggle) rdy = (vcnt == 0 || vcnt >= 3);
                vcnt++;
            end
            out_ready_in = rdy;
            hold = 0;
            if (valid_out) begin
                if (rdy) begin
                    res[8*beats +: 8] = data_block_out;
                    check_eq("last_flag", last_out, (beats == 1));
                    if (beats == 1) res[16] = overflow_out;
                    beats++;
                end else begin
                    hold = 1;
                    hd   = data_block_out;
                    hl   = last_out;
                end
            end
        end
        check_eq("out_beats", beats, 2);
        out_ready_in = 1'b1;
        @(negedge clk_in);
        check_eq("idle_valid", valid_out, 0);
        check_eq("idle_ready", ready_out, 1);
        check_eq("idle_busy", busy_out, 0);
    endtask

    task automatic run(input string name, input logic [31:0] t, input logic [16:0] exp,
                       input bit toggle, input bit gap, input bit junk);
        logic [16:0] res;
        int          lat;
        send_t(t, gap, junk);
        collect(toggle, res, lat);
        check_eq({name, "_res"}, res, exp);
        check_eq({name, "_lat"}, (lat >= 0 && lat <= LAT_MAX), 1);
    endtask

    initial begin
        logic [16:0] res;
        logic [31:0] t;
        logic [15:0] r;
        int          lat;

        rst_in       = 1'b1;
        valid_in     = 1'b0;
        T_block_in   = '0;
        n_prime_in   = 8'hEF;
        out_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_eq("rst_valid", valid_out, 0);
        check_eq("rst_last", last_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_ovf", overflow_out, 0);
        check_eq("rst_data", data_block_out, 0);
        check_eq("rst_addr", modN_addr_out, 0);
        check_eq("rst_ready", ready_out, 1);
        rst_in = 1'b0;

        run("zero",   32'h0000_0000, 17'h0_0000, 0, 0, 0);
        run("one_r",  32'h0001_0000, 17'h0_0001, 0, 1, 0);
        run("t_one",  32'h0000_0001, 17'h0_000F, 0, 0, 1);
        run("t240r",  32'h00F0_0000, 17'h0_00F0, 0, 0, 0);
        run("t240rt", 32'h00F0_0000, 17'h0_00F0, 1, 0, 0);
        run("mixed",  32'h00A1_B2C3, {1'b0, ref_reduce(32'h00A1_B2C3)}, 1, 1, 1);

        // Abort during the multiply-accumulate phase, then reuse the block.
        send_t(32'h0000_0001, 0, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check_eq("abort_valid", valid_out, 0);
        check_eq("abort_busy", busy_out, 0);
        check_eq("abort_ready", ready_out, 1);
        check_eq("abort_data", data_block_out, 0);
        check_eq("abort_addr", modN_addr_out, 0);
        rst_in = 1'b0;
        run("after_abort", 32'h0001_0000, 17'h0_0001, 0, 0, 0);

        for (int v = 0; v < 1000; v++) begin
            t = $urandom_range(241 * 65536 - 1, 0);
            r = ref_reduce(t);
            send_t(t, 0, 0);
            collect(v[0], res, lat);
`ifdef MONT_REDUCE_LAZY_EN
            check_eq("sweep_mod", res % 241, r);
            check_eq("sweep_lt2n", (res < 17'd482), 1);
`else
            check_eq("sweep", res, {1'b0, r});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
